// File: rtl/post_period_timer.sv
// post_period_timer
//
// Post-level period timer with a multi-digit 7-segment readout.
// A start request runs a PERIOD_SEC-second period, timed by an internal
// prescaler that wraps every CLK_TICKS_PER_SEC cycles. When the period ends
// normally, levelComplete pulses for one cycle. At the same time, a sequential
// double-dabble converter keeps turning magicSymbolCount into segment patterns.
//
// Ports:
//   Clk100M          in   system clock
//   Reset            in   synchronous, active-high reset
//   postSig          in   start request (ignored while running)
//   postAbort        in   cancel the running period, no completion pulse
//   magicSymbolCount in   binary value to display (COUNT_W bits)
//   levelComplete    out  one-cycle completion pulse
//   busy             out  high while the period is running
//   secondsLeft      out  remaining whole seconds, 0 when idle
//   postSeg          out  active-low segment bus, bits [7:0] = least-significant digit
//
// Optional feature macro: POST_PERIOD_BLINK_EN
//   When defined, the display blinks during the final second of the period.
//   The count is shown and blanked in alternation, every CLK_TICKS_PER_SEC/4
//   cycles.
module post_period_timer #(
  parameter int CLK_TICKS_PER_SEC = 100000000,
  parameter int PERIOD_SEC        = 5,
  parameter int COUNT_W           = 8,
  parameter int NUM_DIGITS        = 2
) (
  input  logic                            Clk100M,
  input  logic                            Reset,
  input  logic                            postSig,
  input  logic                            postAbort,
  input  logic [COUNT_W-1:0]              magicSymbolCount,
  output logic                            levelComplete,
  output logic                            busy,
  output logic [$clog2(PERIOD_SEC+1)-1:0] secondsLeft,
  output logic [8*NUM_DIGITS-1:0]         postSeg
);

  localparam int SEC_W = $clog2(PERIOD_SEC + 1);
  localparam int PRE_W = (CLK_TICKS_PER_SEC > 1) ? $clog2(CLK_TICKS_PER_SEC) : 1;
  localparam int BIT_W = $clog2(COUNT_W + 1);
  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int SEG_W = 8 * NUM_DIGITS;

  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(CLK_TICKS_PER_SEC - 1);
  localparam logic [SEC_W-1:0] SEC_LAST  = SEC_W'(PERIOD_SEC - 1);
  localparam logic [SEC_W-1:0] SEC_TOTAL = SEC_W'(PERIOD_SEC);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(COUNT_W);
  localparam logic [63:0]      MAX_SHOWN = 64'(10 ** NUM_DIGITS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [PRE_W-1:0]   prescaler_q, prescaler_d;
  logic [SEC_W-1:0]   sec_cnt_q, sec_cnt_d;
  logic               level_complete_q, level_complete_d;
  logic               busy_q, busy_d;
  logic [SEC_W-1:0]   seconds_left_q, seconds_left_d;
  logic               tick;

  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [COUNT_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d, bcd_adj;
  logic               ovf_q, ovf_d;
  logic               have_result_q, have_result_d;
  logic [SEG_W-1:0]   seg_val_q, seg_val_d;

  // Active-low digit patterns, with the decimal point always off.
  function automatic logic [7:0] seg7(input logic [3:0] digit);
    case (digit)
      4'd0:    seg7 = 8'hC0;
      4'd1:    seg7 = 8'hF9;
      4'd2:    seg7 = 8'hA4;
      4'd3:    seg7 = 8'hB0;
      4'd4:    seg7 = 8'h99;
      4'd5:    seg7 = 8'h92;
      4'd6:    seg7 = 8'h82;
      4'd7:    seg7 = 8'hF8;
      4'd8:    seg7 = 8'h80;
      4'd9:    seg7 = 8'h90;
      default: seg7 = 8'hFF;
    endcase
  endfunction

  // Timer next-state logic.
  // An abort has priority over both a start and the final tick. The outputs
  // are computed from the next state, so their registers line up with the
  // state register.
  always_comb begin
    state_d          = state_q;
    prescaler_d      = prescaler_q;
    sec_cnt_d        = sec_cnt_q;
    level_complete_d = 1'b0;
    tick             = (prescaler_q == PRE_LAST);
    case (state_q)
      IDLE: begin
        if (postSig && !postAbort) begin
          state_d     = RUN;
          prescaler_d = '0;
          sec_cnt_d   = '0;
        end
      end
      RUN: begin
        if (postAbort) begin
          state_d = IDLE;
        end else if (tick) begin
          prescaler_d = '0;
          if (sec_cnt_q == SEC_LAST) begin
            state_d          = IDLE;
            sec_cnt_d        = '0;
            level_complete_d = 1'b1;
          end else begin
            sec_cnt_d = sec_cnt_q + SEC_W'(1);
          end
        end else begin
          prescaler_d = prescaler_q + PRE_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d         = (state_d == RUN);
    seconds_left_d = busy_d ? (SEC_TOTAL - sec_cnt_d) : '0;
  end

  always_ff @(posedge Clk100M) begin
    if (Reset) begin
      state_q          <= IDLE;
      prescaler_q      <= '0;
      sec_cnt_q        <= '0;
      level_complete_q <= 1'b0;
      busy_q           <= 1'b0;
      seconds_left_q   <= '0;
    end else begin
      state_q          <= state_d;
      prescaler_q      <= prescaler_d;
      sec_cnt_q        <= sec_cnt_d;
      level_complete_q <= level_complete_d;
      busy_q           <= busy_d;
      seconds_left_q   <= seconds_left_d;
    end
  end

  // Display converter. Each conversion takes COUNT_W+1 cycles:
  //   - one load cycle, with bit_cnt == 0;
  //   - then COUNT_W add-3-and-shift cycles.
  // The load cycle does three things:
  //   - latches a fresh input, so a mid-conversion change is not seen;
  //   - records whether that input overflows the display;
  //   - publishes the result of the previous conversion in one step.
  // have_result keeps the display blank until the first conversion completes.
  always_comb begin
    bit_cnt_d     = bit_cnt_q;
    bin_d         = bin_q;
    bcd_d         = bcd_q;
    bcd_adj       = bcd_q;
    ovf_d         = ovf_q;
    have_result_d = have_result_q;
    seg_val_d     = seg_val_q;
    if (bit_cnt_q == '0) begin
      if (have_result_q) begin
        for (int d = 0; d < NUM_DIGITS; d++) begin
          seg_val_d[8*d +: 8] = ovf_q ? 8'hBF : seg7(bcd_q[4*d +: 4]);
        end
      end
      bin_d     = magicSymbolCount;
      bcd_d     = '0;
      ovf_d     = (64'(magicSymbolCount) > MAX_SHOWN);
      bit_cnt_d = BIT_W'(1);
    end else begin
      for (int d = 0; d < NUM_DIGITS; d++) begin
        if (bcd_q[4*d +: 4] >= 4'd5) begin
          bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
        end
      end
      {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
      if (bit_cnt_q == BIT_LAST) begin
        bit_cnt_d     = '0;
        have_result_d = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + BIT_W'(1);
      end
    end
  end

  always_ff @(posedge Clk100M) begin
    if (Reset) begin
      bit_cnt_q     <= '0;
      bin_q         <= '0;
      bcd_q         <= '0;
      ovf_q         <= 1'b0;
      have_result_q <= 1'b0;
      seg_val_q     <= '1;
    end else begin
      bit_cnt_q     <= bit_cnt_d;
      bin_q         <= bin_d;
      bcd_q         <= bcd_d;
      ovf_q         <= ovf_d;
      have_result_q <= have_result_d;
      seg_val_q     <= seg_val_d;
    end
  end

`ifdef POST_PERIOD_BLINK_EN
  localparam int BLINK_TICKS = (CLK_TICKS_PER_SEC / 4 > 0) ? CLK_TICKS_PER_SEC / 4 : 1;
  localparam int BL_W        = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [BL_W-1:0] BLINK_LAST = BL_W'(BLINK_TICKS - 1);

  logic [BL_W-1:0]  blink_cnt_q, blink_cnt_d;
  logic             blank_q, blank_d;
  logic             final_sec_d, final_sec_q;
  logic [SEG_W-1:0] post_seg_q, post_seg_d;

  // Blink phase tracking.
  // This uses the same next-cycle view as secondsLeft, so blanking lines up
  // with the "1" second. Each final second starts with the count shown.
  always_comb begin
    final_sec_d = (seconds_left_d == SEC_W'(1));
    final_sec_q = (seconds_left_q == SEC_W'(1));
    blink_cnt_d = '0;
    blank_d     = 1'b0;
    if (final_sec_d && final_sec_q) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blank_d = !blank_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BL_W'(1);
        blank_d     = blank_q;
      end
    end
    post_seg_d = blank_d ? '1 : seg_val_d;
  end

  always_ff @(posedge Clk100M) begin
    if (Reset) begin
      blink_cnt_q <= '0;
      blank_q     <= 1'b0;
      post_seg_q  <= '1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blank_q     <= blank_d;
      post_seg_q  <= post_seg_d;
    end
  end

  assign postSeg = post_seg_q;
`else
  assign postSeg = seg_val_q;
`endif

  assign levelComplete = level_complete_q;
  assign busy          = busy_q;
  assign secondsLeft   = seconds_left_q;

endmodule

// File: tb/tb_post_period_timer.sv
// Directed testbench for post_period_timer, using a small configuration:
//   4 ticks per second, 3-second period, 8-bit count, 2 digits.
// Every check samples 1 time unit after the rising edge, which is also when
// inputs are driven. A period started in cycle T completes in cycle T+13.
module tb_post_period_timer;

  logic        Clk100M = 1'b0;
  logic        Reset = 1'b1;
  logic        postSig = 1'b0;
  logic        postAbort = 1'b0;
  logic [7:0]  magicSymbolCount = 8'd0;
  logic        levelComplete;
  logic        busy;
  logic [1:0]  secondsLeft;
  logic [15:0] postSeg;

  int errors = 0;
  int checks = 0;

  post_period_timer #(
    .CLK_TICKS_PER_SEC(4),
    .PERIOD_SEC(3),
    .COUNT_W(8),
    .NUM_DIGITS(2)
  ) dut (
    .Clk100M(Clk100M),
    .Reset(Reset),
    .postSig(postSig),
    .postAbort(postAbort),
    .magicSymbolCount(magicSymbolCount),
    .levelComplete(levelComplete),
    .busy(busy),
    .secondsLeft(secondsLeft),
    .postSeg(postSeg)
  );

  always #5 Clk100M = ~Clk100M;

  // Advance n rising edges and settle just past the last one
  task automatic step(input int n);
    repeat (n) @(posedge Clk100M);
    #1;
  endtask

  task automatic applyStimulus(input logic sig, input logic abort);
    postSig   = sig;
    postAbort = abort;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    step(2);
    Reset = 1'b0;
    step(1);
    checks++; if (postSeg !== 16'hFFFF) begin errors++; $display("[TB] FAIL reset_seg: got %h expected ffff", postSeg); end
    checks++; if (levelComplete !== 1'b0) begin errors++; $display("[TB] FAIL reset_lc: got %b expected 0", levelComplete); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (secondsLeft !== 2'd0) begin errors++; $display("[TB] FAIL reset_secleft: got %0d expected 0", secondsLeft); end
  endtask

  task automatic test_display();
    logic [7:0]  vals [7];
    logic [15:0] exps [7];
    vals = '{8'd47, 8'd123, 8'd0, 8'd99, 8'd100, 8'd255, 8'd5};
    exps = '{16'h99F8, 16'hBFBF, 16'hC0C0, 16'h9090, 16'hBFBF, 16'hBFBF, 16'hC092};
    for (int i = 0; i < 7; i++) begin
      magicSymbolCount = vals[i];
      step(18);
      checks++;
      if (postSeg !== exps[i]) begin
        errors++;
        $display("[TB] FAIL display_%0d: got %h expected %h", vals[i], postSeg, exps[i]);
      end
    end
    // A change in the middle of a conversion must only be picked up by a later conversion
    magicSymbolCount = 8'd58;
    step(5);
    magicSymbolCount = 8'd31;
    step(18);
    checks++; if (postSeg !== 16'hB0F9) begin errors++; $display("[TB] FAIL display_midchange: got %h expected b0f9", postSeg); end
  endtask

  task automatic test_period();
    logic       exp_busy;
    logic       exp_lc;
    logic [1:0] exp_sl;
    applyStimulus(1'b1, 1'b0);
    for (int k = 1; k <= 14; k++) begin
      step(1);
      applyStimulus(1'b0, 1'b0);
      exp_busy = (k <= 12);
      exp_lc   = (k == 13);
      exp_sl   = (k <= 12) ? 2'(3 - (k - 1) / 4) : 2'd0;
      checks++; if (busy !== exp_busy) begin errors++; $display("[TB] FAIL period_busy_T+%0d: got %b expected %b", k, busy, exp_busy); end
      checks++; if (secondsLeft !== exp_sl) begin errors++; $display("[TB] FAIL period_secleft_T+%0d: got %0d expected %0d", k, secondsLeft, exp_sl); end
      checks++; if (levelComplete !== exp_lc) begin errors++; $display("[TB] FAIL period_lc_T+%0d: got %b expected %b", k, levelComplete, exp_lc); end
    end
  endtask

  task automatic test_back_to_back();
    // A start request while running must not disturb the pulse timing
    applyStimulus(1'b1, 1'b0);
    step(1);
    applyStimulus(1'b0, 1'b0);
    step(4);
    applyStimulus(1'b1, 1'b0);
    step(1);
    applyStimulus(1'b0, 1'b0);
    for (int k = 7; k <= 16; k++) begin
      step(1);
      checks++; if (levelComplete !== (k == 13)) begin errors++; $display("[TB] FAIL ignore_lc_T+%0d: got %b expected %b", k, levelComplete, (k == 13)); end
    end
    // With postSig held high, a new period starts on the cycle after completion
    applyStimulus(1'b1, 1'b0);
    step(13);
    checks++; if (levelComplete !== 1'b1) begin errors++; $display("[TB] FAIL held_lc: got %b expected 1", levelComplete); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL held_busy_done: got %b expected 0", busy); end
    step(1);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL held_restart_busy: got %b expected 1", busy); end
    checks++; if (secondsLeft !== 2'd3) begin errors++; $display("[TB] FAIL held_restart_secleft: got %0d expected 3", secondsLeft); end
    checks++; if (levelComplete !== 1'b0) begin errors++; $display("[TB] FAIL held_restart_lc: got %b expected 0", levelComplete); end
    applyStimulus(1'b0, 1'b1);
    step(1);
    applyStimulus(1'b0, 1'b0);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL held_abort_busy: got %b expected 0", busy); end
  endtask

  task automatic test_abort();
    int pulses;
    applyStimulus(1'b1, 1'b0);
    step(1);
    applyStimulus(1'b0, 1'b0);
    step(5);
    applyStimulus(1'b0, 1'b1);
    step(1);
    applyStimulus(1'b0, 1'b0);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
    checks++; if (secondsLeft !== 2'd0) begin errors++; $display("[TB] FAIL abort_secleft: got %0d expected 0", secondsLeft); end
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      if (levelComplete === 1'b1) pulses++;
      step(1);
    end
    checks++; if (pulses !== 0) begin errors++; $display("[TB] FAIL abort_no_pulse: got %0d pulses expected 0", pulses); end
    // Abort wins over a simultaneous start in IDLE
    applyStimulus(1'b1, 1'b1);
    step(1);
    applyStimulus(1'b0, 1'b0);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_vs_start_busy: got %b expected 0", busy); end
    // Abort wins over the final tick
    applyStimulus(1'b1, 1'b0);
    step(1);
    applyStimulus(1'b0, 1'b0);
    step(11);
    checks++; if (secondsLeft !== 2'd1) begin errors++; $display("[TB] FAIL final_tick_secleft: got %0d expected 1", secondsLeft); end
    applyStimulus(1'b0, 1'b1);
    step(1);
    applyStimulus(1'b0, 1'b0);
    checks++; if (levelComplete !== 1'b0) begin errors++; $display("[TB] FAIL final_tick_abort_lc: got %b expected 0", levelComplete); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL final_tick_abort_busy: got %b expected 0", busy); end
    step(1);
    checks++; if (levelComplete !== 1'b0) begin errors++; $display("[TB] FAIL final_tick_abort_late_lc: got %b expected 0", levelComplete); end
  endtask

  task automatic test_reset_mid_run();
    int pulses;
    applyStimulus(1'b1, 1'b0);
    step(1);
    applyStimulus(1'b0, 1'b0);
    step(4);
    Reset = 1'b1;
    step(1);
    Reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy: got %b expected 0", busy); end
    checks++; if (secondsLeft !== 2'd0) begin errors++; $display("[TB] FAIL midreset_secleft: got %0d expected 0", secondsLeft); end
    checks++; if (postSeg !== 16'hFFFF) begin errors++; $display("[TB] FAIL midreset_seg: got %h expected ffff", postSeg); end
    pulses = 0;
    for (int k = 0; k < 14; k++) begin
      step(1);
      if (levelComplete === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("[TB] FAIL midreset_no_pulse: got %0d pulses expected 0", pulses); end
  endtask

  initial begin
    $display("[TB] post_period_timer directed tests");
    test_reset();
    test_display();
    test_period();
    test_back_to_back();
    test_abort();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
